// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_EX = 2'd2,
        RESP   = 2'd3
    } state_t;
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } owner_t;
    localparam logic [3:0] FETCH_BE = 4'hF;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, execute and memory-side signals of the shared port
interface mem_port_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_data_o;
    logic        ex_req_i;
    logic        ex_we_i;
    logic [3:0]  ex_be_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ack_o;
    logic [31:0] ex_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        timeout_o;
    logic        busy_o;
    modport slave (
        input  if_req_i, if_addr_i, ex_req_i, ex_we_i, ex_be_i, ex_addr_i, ex_wdata_i,
               mem_rdata_i, mem_ack_i,
        output if_ack_o, if_data_o, ex_ack_o, ex_rdata_o, mem_req_o, mem_we_o, mem_be_o,
               mem_addr_o, mem_wdata_o, timeout_o, busy_o
    );
    modport master (
        output if_req_i, if_addr_i, ex_req_i, ex_we_i, ex_be_i, ex_addr_i, ex_wdata_i,
               mem_rdata_i, mem_ack_i,
        input  if_ack_o, if_data_o, ex_ack_o, ex_rdata_o, mem_req_o, mem_we_o, mem_be_o,
               mem_addr_o, mem_wdata_o, timeout_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// mem_arb_timeout: per-transaction wait counter that flags a hung memory access
module mem_arb_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [W-1:0] r_cnt;
    // count wait cycles while a grant is outstanding, restart from zero otherwise
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + W'(1);
    assign o_expired = (TIMEOUT_CYC != 0) && (r_cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and execute, execute first with a starvation limit
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    state_t        r_state,     w_nxt_state;
    owner_t        r_owner,     w_nxt_owner;
    logic [SW-1:0] r_starve,    w_nxt_starve;
    logic          r_mem_req,   w_nxt_mem_req;
    logic          r_mem_we,    w_nxt_mem_we;
    logic [3:0]    r_mem_be,    w_nxt_mem_be;
    logic [31:0]   r_mem_addr,  w_nxt_mem_addr;
    logic [31:0]   r_mem_wdata, w_nxt_mem_wdata;
    logic          r_if_ack,    w_nxt_if_ack;
    logic [31:0]   r_if_data,   w_nxt_if_data;
    logic          r_ex_ack,    w_nxt_ex_ack;
    logic [31:0]   r_ex_rdata,  w_nxt_ex_rdata;
    logic          r_timeout,   w_nxt_timeout;
    logic          r_busy;
    logic          w_in_gnt;
    logic          w_expired;
    logic          w_done;
    assign w_in_gnt = (r_state == GNT_IF) || (r_state == GNT_EX);
    assign w_done   = bus.mem_ack_i || w_expired;
    mem_arb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clr     (!w_in_gnt),
        .i_en      (w_in_gnt),
        .o_expired (w_expired)
    );
    // arbitration, capture of the winning request and completion of the grant
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_owner     = r_owner;
        w_nxt_starve    = r_starve;
        w_nxt_mem_req   = r_mem_req;
        w_nxt_mem_we    = r_mem_we;
        w_nxt_mem_be    = r_mem_be;
        w_nxt_mem_addr  = r_mem_addr;
        w_nxt_mem_wdata = r_mem_wdata;
        w_nxt_if_ack    = 1'b0;
        w_nxt_if_data   = '0;
        w_nxt_ex_ack    = 1'b0;
        w_nxt_ex_rdata  = '0;
        w_nxt_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ex_req_i && (r_starve < SW'(STARVE_MAX) || !bus.if_req_i)) begin
                    w_nxt_state     = GNT_EX;
                    w_nxt_owner     = OWN_EX;
                    w_nxt_starve    = bus.if_req_i ? r_starve + SW'(1) : '0;
                    w_nxt_mem_req   = 1'b1;
                    w_nxt_mem_we    = bus.ex_we_i;
                    w_nxt_mem_be    = bus.ex_be_i;
                    w_nxt_mem_addr  = bus.ex_addr_i;
                    w_nxt_mem_wdata = bus.ex_wdata_i;
                end else if (bus.if_req_i) begin
                    w_nxt_state     = GNT_IF;
                    w_nxt_owner     = OWN_IF;
                    w_nxt_starve    = '0;
                    w_nxt_mem_req   = 1'b1;
                    w_nxt_mem_we    = 1'b0;
                    w_nxt_mem_be    = FETCH_BE;
                    w_nxt_mem_addr  = bus.if_addr_i;
                    w_nxt_mem_wdata = '0;
                end
            end
            GNT_IF, GNT_EX: begin
                if (w_done) begin
                    w_nxt_state    = RESP;
                    w_nxt_mem_req  = 1'b0;
                    w_nxt_if_ack   = (r_owner == OWN_IF);
                    w_nxt_ex_ack   = (r_owner == OWN_EX);
                    w_nxt_if_data  = (r_owner == OWN_IF && bus.mem_ack_i) ? bus.mem_rdata_i : '0;
                    w_nxt_ex_rdata = (r_owner == OWN_EX && bus.mem_ack_i && !r_mem_we) ? bus.mem_rdata_i : '0;
                    w_nxt_timeout  = !bus.mem_ack_i;
                end
            end
            RESP: w_nxt_state = IDLE;
        endcase
    end
    // state and every output are registered; reset abandons any access in flight
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_starve    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_data   <= '0;
            r_ex_ack    <= 1'b0;
            r_ex_rdata  <= '0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_owner     <= w_nxt_owner;
            r_starve    <= w_nxt_starve;
            r_mem_req   <= w_nxt_mem_req;
            r_mem_we    <= w_nxt_mem_we;
            r_mem_be    <= w_nxt_mem_be;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
            r_if_ack    <= w_nxt_if_ack;
            r_if_data   <= w_nxt_if_data;
            r_ex_ack    <= w_nxt_ex_ack;
            r_ex_rdata  <= w_nxt_ex_rdata;
            r_timeout   <= w_nxt_timeout;
            r_busy      <= (w_nxt_state != IDLE);
        end
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_be_o    = r_mem_be;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;
    assign bus.if_ack_o    = r_if_ack;
    assign bus.if_data_o   = r_if_data;
    assign bus.ex_ack_o    = r_ex_ack;
    assign bus.ex_rdata_o  = r_ex_rdata;
    assign bus.timeout_o   = r_timeout;
    assign bus.busy_o      = r_busy;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (read-only) and the execute stage (loads and stores).
- Only one memory transaction is in flight at a time.
- Execute has priority over fetch, with a starvation limit so fetch always makes progress.
- A per-transaction timeout aborts a hung memory access and returns an error pulse to the requester.

Parameters:
- STARVE_MAX, 4: consecutive execute grants allowed while fetch is waiting; after that, fetch wins once.
- TIMEOUT_CYC, 255: cycles a transaction may wait for mem_ack_i before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held with if_addr_i until if_ack_o
- if_addr_i  in  32  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_data_o  out  32  fetch read data; valid when if_ack_o=1
- ex_req_i  in  1  execute request; held with all ex_* fields until ex_ack_o
- ex_we_i  in  1  1 = store, 0 = load
- ex_be_i  in  4  byte enables
- ex_addr_i  in  32  load/store address
- ex_wdata_i  in  32  store data
- ex_ack_o  out  1  one-cycle execute completion pulse
- ex_rdata_o  out  32  load data; valid when ex_ack_o=1; 0 for stores
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data; valid with mem_ack_i
- mem_ack_i  in  1  memory completion; may arrive in the same cycle mem_req_o rises
- timeout_o  out  1  one-cycle pulse coincident with the aborted requester's ack
- busy_o  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All outputs go to 0: mem_*, ack, data, timeout_o, busy_o.
  - FSM goes to IDLE; starve_cnt and tmo_cnt go to 0.
  - Any in-flight transaction is abandoned; memory must tolerate mem_req_o dropping mid-access.
- FSM states: IDLE, GNT_IF, GNT_EX, RESP. All outputs are registered.
- IDLE:
  - ex_req_i=1 and (starve_cnt<STARVE_MAX or if_req_i=0) -> GNT_EX.
  - Else if_req_i=1 -> GNT_IF.
  - Else stay in IDLE.
  - On the granting edge, capture address, be, we and wdata into mem_* and set mem_req_o=1.
  - Fetch is presented as be=4'hF, we=0, wdata=0.
- Starvation counter (starve_cnt):
  - EX grant while if_req_i=1 -> increment, saturating at STARVE_MAX.
  - IF grant -> clear.
  - EX grant while if_req_i=0 -> clear.
- GNT_IF / GNT_EX:
  - mem_req_o and mem_* fields are held stable.
  - tmo_cnt increments every cycle.
  - mem_ack_i=1 -> RESP: mem_req_o=0, the granted requester's ack_o=1, its data_o=mem_rdata_i (0 for stores).
  - tmo_cnt==TIMEOUT_CYC-1 with no ack (TIMEOUT_CYC>0) -> RESP: mem_req_o=0, ack_o=1, data_o=0, timeout_o=1.
  - If ack and timeout occur in the same cycle, the ack wins and timeout_o=0.
- RESP (exactly 1 cycle):
  - ack_o and timeout_o are asserted only in RESP.
  - No arbitration happens in RESP, so a requester dropping req_i is never re-granted.
  - Next state IDLE; the data output returns to 0.
- Latency: request sampled at edge N -> mem_req_o high after edge N. mem_ack_i sampled at edge M -> ack_o high for cycle M+1. Minimum 3 cycles from request to next arbitration.
- A request deasserted before its grant is legal; it is simply not granted.
- Requests that change while granted are protocol violations; captured values are used.
- Simultaneous if_req_i and ex_req_i: EX wins unless starve_cnt==STARVE_MAX.
- busy_o=1 in GNT_IF, GNT_EX and RESP.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE=2'd0, GNT_IF=2'd1, GNT_EX=2'd2, RESP=2'd3);
  - the grant-owner encoding;
  - FETCH_BE=4'hF.
- One natural sub-module: mem_arb_timeout, a loadable counter with clear/enable/expired and the TIMEOUT_CYC parameter.
- Arbitration and the FSM stay in the top level.

Test Plan:
- Single load: ex_req_i=1, we=0, addr=0x100; mem_ack_i one cycle after mem_req_o with rdata=0xDEADBEEF -> mem_addr_o=0x100, be=ex_be_i; ex_ack_o 1-cycle pulse with ex_rdata_o=0xDEADBEEF; if_ack_o stays 0.
- Store, zero-wait memory: ex_we_i=1, be=4'b0011, wdata=0x1234ABCD, mem_ack_i tied high -> one mem_req_o cycle with we=1, be=0011, wdata=0x1234ABCD; ex_ack_o=1 with ex_rdata_o=0; IDLE 2 cycles after mem_req_o.
- Starvation, STARVE_MAX=4: if_req_i and ex_req_i held continuously (execute re-requests immediately) -> grant order EX,EX,EX,EX,IF,EX,...; starve_cnt clears after the IF grant.
- Timeout, TIMEOUT_CYC=8: mem_ack_i never asserted -> mem_req_o high exactly 8 cycles, then ex_ack_o=1, timeout_o=1, ex_rdata_o=0; the next request proceeds normally.
- Async reset mid-transaction: rst_i=0 while in GNT_IF with mem_req_o=1 -> all outputs 0 immediately, without waiting for a clock edge; after release with if_req_i=1 -> fresh IF grant next edge.
- Ack/timeout collision, TIMEOUT_CYC=4: mem_ack_i on the 4th wait cycle -> normal ack with data; timeout_o stays 0.
